// File: rtl/cpu_soc_top.sv
// Evergreen mini-CPU board wrapper: tick divider, multi-cycle 16-bit CPU, 64x16 memory, LED/HEX output.
// Define HEX_DISPLAY_EN to build the seven-segment decoder; otherwise all segments stay off.

module cpu_soc_mem (
  input  logic        clk,
  input  logic        i_we,
  input  logic [5:0]  i_waddr,
  input  logic [15:0] i_wdata,
  input  logic [5:0]  i_raddr,
  output logic [15:0] o_rdata
);
  logic [15:0] mem [64];

  // NOTE: memory is never reset; contents survive rst and come from a preload or earlier writes.
  always_ff @(posedge clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem[i_raddr];
endmodule

module cpu_soc_top #(
  parameter int DIVISOR = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  btn,
  input  logic [8:0]  sw,
  output logic [9:0]  led,
  output logic [27:0] hex
);
  localparam int              DIV_W   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DIVISOR - 1);

  localparam logic [2:0] S_FETCH   = 3'd0;
  localparam logic [2:0] S_OPB_PTR = 3'd1;
  localparam logic [2:0] S_OPB     = 3'd2;
  localparam logic [2:0] S_OPC_PTR = 3'd3;
  localparam logic [2:0] S_OPC     = 3'd4;
  localparam logic [2:0] S_ADDRA   = 3'd5;
  localparam logic [2:0] S_EXEC    = 3'd6;
  localparam logic [2:0] S_HALT    = 3'd7;

  localparam logic [3:0] OP_MOV  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_MUL  = 4'h3;
  localparam logic [3:0] OP_IN   = 4'h7;
  localparam logic [3:0] OP_OUT  = 4'h8;
  localparam logic [3:0] OP_STOP = 4'hF;

  logic [DIV_W-1:0] r_div;
  logic [2:0]       r_state;
  logic [5:0]       r_pc;
  logic [15:0]      r_ir;
  logic [15:0]      r_opb;
  logic [15:0]      r_opc;
  logic [5:0]       r_ptr;
  logic [5:0]       r_addr_a;
  logic [15:0]      r_out;

  logic        w_tick;
  logic [3:0]  w_op;
  logic        w_three;
  logic        w_writes;
  logic        w_we;
  logic [5:0]  w_raddr;
  logic [15:0] w_rdata;
  logic [15:0] w_wdata;
  logic        w_unused;

  assign w_unused = ^btn;
  assign w_tick   = (r_div == DIV_MAX);
  assign w_op     = r_ir[15:12];
  assign w_three  = (w_op == OP_ADD) || (w_op == OP_SUB) || (w_op == OP_MUL);
  assign w_writes = w_three || (w_op == OP_MOV) || (w_op == OP_IN);
  // rst masks the write so an abandoned instruction never lands in memory.
  assign w_we     = w_tick && !rst && (r_state == S_EXEC) && w_writes;

  function automatic logic [2:0] after_fetch(input logic [15:0] word);
    logic [2:0] nxt;
    nxt = S_FETCH;
    case (word[15:12])
      OP_MOV, OP_ADD, OP_SUB, OP_MUL: nxt = word[7] ? S_OPB_PTR : S_OPB;
      OP_IN, OP_OUT:                  nxt = S_ADDRA;
      OP_STOP:                        nxt = S_HALT;
      default:                        nxt = S_FETCH;
    endcase
    return nxt;
  endfunction

  // NOTE: every signal driven in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    w_raddr = r_pc;
    case (r_state)
      S_OPB_PTR: w_raddr = {3'b0, r_ir[6:4]};
      S_OPB:     w_raddr = r_ir[7] ? r_ptr : {3'b0, r_ir[6:4]};
      S_OPC_PTR: w_raddr = {3'b0, r_ir[2:0]};
      S_OPC:     w_raddr = r_ir[3] ? r_ptr : {3'b0, r_ir[2:0]};
      S_ADDRA:   w_raddr = {3'b0, r_ir[10:8]};
      S_EXEC:    w_raddr = r_addr_a;
      default:   w_raddr = r_pc;
    endcase
  end

  always_comb begin
    w_wdata = r_opb;
    case (w_op)
      OP_ADD:  w_wdata = r_opb + r_opc;
      OP_SUB:  w_wdata = r_opb - r_opc;
      OP_MUL:  w_wdata = r_opb * r_opc;
      OP_IN:   w_wdata = {7'b0, sw};
      default: w_wdata = r_opb;
    endcase
  end

  cpu_soc_mem my_memory (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_addr_a),
    .i_wdata (w_wdata),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || w_tick) r_div <= '0;
    else               r_div <= r_div + DIV_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_FETCH;
      r_pc     <= 6'd8;
      r_ir     <= '0;
      r_opb    <= '0;
      r_opc    <= '0;
      r_ptr    <= '0;
      r_addr_a <= '0;
      r_out    <= '0;
    end else if (w_tick) begin
      case (r_state)
        S_FETCH: begin
          r_ir    <= w_rdata;
          r_pc    <= r_pc + 6'd1;
          r_state <= after_fetch(w_rdata);
        end
        S_OPB_PTR: begin
          r_ptr   <= w_rdata[5:0];
          r_state <= S_OPB;
        end
        S_OPB: begin
          r_opb   <= w_rdata;
          r_state <= w_three ? (r_ir[3] ? S_OPC_PTR : S_OPC) : S_ADDRA;
        end
        S_OPC_PTR: begin
          r_ptr   <= w_rdata[5:0];
          r_state <= S_OPC;
        end
        S_OPC: begin
          r_opc   <= w_rdata;
          r_state <= S_ADDRA;
        end
        S_ADDRA: begin
          r_addr_a <= r_ir[11] ? w_rdata[5:0] : {3'b0, r_ir[10:8]};
          r_state  <= S_EXEC;
        end
        S_EXEC: begin
          if (w_op == OP_OUT) r_out <= w_rdata;
          r_state <= S_FETCH;
        end
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  assign led = r_out[9:0];

`ifdef HEX_DISPLAY_EN
  function automatic logic [6:0] seg7(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;  4'h1: seg = 7'h79;  4'h2: seg = 7'h24;  4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;  4'h5: seg = 7'h12;  4'h6: seg = 7'h02;  4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;  4'h9: seg = 7'h10;  4'hA: seg = 7'h08;  4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;  4'hD: seg = 7'h21;  4'hE: seg = 7'h06;  default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

  assign hex = {seg7(r_out[15:12]), seg7(r_out[11:8]), seg7(r_out[7:4]), seg7(r_out[3:0])};
`else
  assign hex = '1;
`endif
endmodule

// File: tb/tb_cpu_soc_top.sv
// Directed bench for cpu_soc_top (DIVISOR=5): reset, IN/OUT/STOP, arithmetic, indirect, hex, live input.
// Hex expectations follow HEX_DISPLAY_EN when the bench is built with it.

module tb_cpu_soc_top;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  btn;
  logic [8:0]  sw;
  logic [9:0]  led;
  logic [27:0] hex;

  int n_vec = 0;
  int n_err = 0;

`ifdef HEX_DISPLAY_EN
  localparam logic [27:0] HEX_ZERO = {7'h40, 7'h40, 7'h40, 7'h40};
  localparam logic [27:0] HEX_1A3F = {7'h79, 7'h08, 7'h30, 7'h0E};
`else
  localparam logic [27:0] HEX_ZERO = 28'hFFFFFFF;
  localparam logic [27:0] HEX_1A3F = 28'hFFFFFFF;
`endif

  cpu_soc_top #(.DIVISOR(5)) dut (
    .clk (clk),
    .rst (rst),
    .btn (btn),
    .sw  (sw),
    .led (led),
    .hex (hex)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill_nop();
    for (int i = 0; i < 64; i++) dut.my_memory.mem[i] = 16'h4000;
  endtask

  task automatic start_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic end_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_led(input logic [9:0] exp, input int budget, input string tag);
    int n;
    n = 0;
    while (led !== exp && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(led), 32'(exp));
  endtask

  task automatic wait_halt(input int budget, input string tag);
    int n;
    n = 0;
    while (dut.r_state !== 3'd7 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(dut.r_state), 32'd7);
  endtask

  initial begin
    rst = 1'b1;
    btn = 3'b000;
    sw  = 9'h008;

    // IN r1; OUT r1; STOP
    start_reset();
    fill_nop();
    dut.my_memory.mem[8]  = 16'h7100;
    dut.my_memory.mem[9]  = 16'h8100;
    dut.my_memory.mem[10] = 16'hF000;
    repeat (2) @(negedge clk);
    check("rst_led",   32'(led), 32'h0);
    check("rst_hex",   32'(hex), 32'(HEX_ZERO));
    check("rst_pc",    32'(dut.r_pc), 32'd8);
    check("rst_state", 32'(dut.r_state), 32'd0);
    check("rst_div",   32'(dut.r_div), 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("tick_early", 32'(dut.w_tick), 32'd0);
    @(negedge clk);
    check("tick_fifth", 32'(dut.w_tick), 32'd1);
    check("pc_before_tick", 32'(dut.r_pc), 32'd8);
    @(negedge clk);
    check("pc_after_tick", 32'(dut.r_pc), 32'd9);
    wait_halt(200, "io_halt");
    check("io_led", 32'(led), 32'h008);
    repeat (1000) @(negedge clk);
    check("halt_state", 32'(dut.r_state), 32'd7);
    check("halt_led",   32'(led), 32'h008);
    check("halt_pc",    32'(dut.r_pc), 32'd11);

    // Arithmetic including 16-bit wrap
    start_reset();
    fill_nop();
    dut.my_memory.mem[0]  = 16'h0000;
    dut.my_memory.mem[1]  = 16'h0003;
    dut.my_memory.mem[2]  = 16'h0005;
    dut.my_memory.mem[5]  = 16'hFFFF;
    dut.my_memory.mem[6]  = 16'h0001;
    dut.my_memory.mem[7]  = 16'h1234;
    dut.my_memory.mem[8]  = 16'h1012;
    dut.my_memory.mem[9]  = 16'h2321;
    dut.my_memory.mem[10] = 16'h3412;
    dut.my_memory.mem[11] = 16'h8000;
    dut.my_memory.mem[12] = 16'h8300;
    dut.my_memory.mem[13] = 16'h8400;
    dut.my_memory.mem[14] = 16'h1756;
    dut.my_memory.mem[15] = 16'h8700;
    dut.my_memory.mem[16] = 16'hF000;
    end_reset();
    wait_led(10'h008, 1000, "add_led");
    wait_led(10'h002, 1000, "sub_led");
    wait_led(10'h00F, 1000, "mul_led");
    wait_led(10'h000, 1000, "wrap_led");
    wait_halt(500, "arith_halt");
    check("add_mem",  32'(dut.my_memory.mem[0]), 32'h0008);
    check("sub_mem",  32'(dut.my_memory.mem[3]), 32'h0002);
    check("mul_mem",  32'(dut.my_memory.mem[4]), 32'h000F);
    check("wrap_mem", 32'(dut.my_memory.mem[7]), 32'h0000);

    // Indirect read and indirect write
    start_reset();
    fill_nop();
    dut.my_memory.mem[1]  = 16'h0003;
    dut.my_memory.mem[5]  = 16'h0028;
    dut.my_memory.mem[40] = 16'h0019;
    dut.my_memory.mem[8]  = 16'h06D0;
    dut.my_memory.mem[9]  = 16'h8600;
    dut.my_memory.mem[10] = 16'h0D10;
    dut.my_memory.mem[11] = 16'h8D00;
    dut.my_memory.mem[12] = 16'hF000;
    end_reset();
    wait_led(10'h019, 1000, "ind_read_led");
    wait_led(10'h003, 1000, "ind_write_led");
    wait_halt(500, "ind_halt");
    check("ind_r6",    32'(dut.my_memory.mem[6]),  32'h0019);
    check("ind_mem40", 32'(dut.my_memory.mem[40]), 32'h0003);
    check("ind_ptr",   32'(dut.my_memory.mem[5]),  32'h0028);

    // Full 16-bit OUT for the display
    start_reset();
    fill_nop();
    dut.my_memory.mem[2] = 16'h1A3F;
    dut.my_memory.mem[8] = 16'h8200;
    dut.my_memory.mem[9] = 16'hF000;
    end_reset();
    wait_halt(300, "hex_halt");
    check("hex_led",  32'(led), 32'h23F);
    check("hex_word", 32'(hex), 32'(HEX_1A3F));

    // Live input loop: IN r1; OUT r1; NOPs wrap PC back to 8
    start_reset();
    fill_nop();
    dut.my_memory.mem[8] = 16'h7100;
    dut.my_memory.mem[9] = 16'h8100;
    sw = 9'h008;
    end_reset();
    wait_led(10'h008, 2000, "live_008");
    sw = 9'h019;
    wait_led(10'h019, 2000, "live_019");
    sw = 9'h003;
    wait_led(10'h003, 2000, "live_003");
    check("live_running", 32'(dut.r_state != 3'd7), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/cpu_soc_top.md
Name: cpu_soc_top

Overview:
- Top-level board wrapper for the Evergreen mini-CPU system. Contains:
  - a clock-enable divider;
  - a multi-cycle 16-bit three-operand CPU;
  - a 64x16 unified program/data memory, instance name my_memory, array mem, preloadable by $readmemh;
  - LED and 4-digit seven-segment output logic.
- Switches feed the IN instruction. OUT drives the LEDs and HEX displays.

Parameters:
- DIVISOR, default 50_000_000, clk cycles per CPU step (>=1). 1 means the CPU steps every clk.

Ports:
- clk  input  1  system clock; the only clock in the design.
- rst  input  1  synchronous, active-high reset.
- btn  input  3  push buttons; reserved, ignored.
- sw   input  9  switch value read by IN, zero-extended to 16 bits.
- led  output 10  out_reg[9:0].
- hex  output 28  four 7-segment digits, active-low:
  - hex[6:0] = out_reg[3:0]
  - hex[13:7] = out_reg[7:4]
  - hex[20:14] = out_reg[11:8]
  - hex[27:21] = out_reg[15:12]

Behaviour:
- Divider:
  - Counter 0..DIVISOR-1, wraps at DIVISOR-1.
  - tick = 1 for one clk when counter == DIVISOR-1.
  - All CPU state and memory writes update only on clk edges where tick = 1.
  - No derived clocks.
- Memory:
  - 64 words x 16 bits.
  - Combinational read; write on clk edge with tick & we.
  - Contents are not cleared by reset.
- Instruction word:
  - op = [15:12]
  - A = [11:8], B = [7:4], C = [3:0]
  - Each operand: bit 3 = indirect flag, bits 2:0 = register address r (memory words 0..7).
  - Direct operand address = r.
  - Indirect operand address = mem[r][5:0].
- Opcodes (others behave as NOP):
  - 0 MOV: A <= B
  - 1 ADD: A <= B + C (mod 2^16)
  - 2 SUB: A <= B - C (mod 2^16)
  - 3 MUL: A <= low 16 bits of B * C
  - 7 IN: A <= {7'b0, sw}
  - 8 OUT: out_reg <= A
  - F STOP: enter HALT
- FSM, one state per tick:
  - FETCH: IR <= mem[PC]; PC <= PC + 1 (6-bit wrap 63 -> 0).
  - OPB: latch B operand address (resolved indirect), then value into opB. Skipped for IN, OUT, STOP.
  - OPC: latch value into opC. Only for ADD, SUB, MUL.
  - ADDRA: resolve A address.
  - EXEC:
    - write result to A address, or update out_reg for OUT;
    - then return to FETCH.
  - HALT: absorbing; only reset leaves it.
- Operand resolution: an indirect operand costs one extra tick (pointer read) before its value read. Each read is one memory access per tick.
- Sampling: sw is sampled in the EXEC tick of IN.
- Reset (synchronous, priority over tick):
  - PC = 8
  - state = FETCH
  - IR = 0, opB = opC = 0
  - out_reg = 0, so led = 0 and hex shows "0000"
  - divider counter = 0
- Hazards:
  - Self-modifying code is allowed; a write takes effect before the next FETCH.
  - If A and B are the same address, the operand value is read before the write.
- Reset mid-instruction: abandons the instruction with no partial memory write.

Optional Feature:
- HEX_DISPLAY_EN:
  - Defined: hex decodes out_reg nibbles 0-F into active-low 7-segment patterns (segment a = bit 0 .. g = bit 6).
  - Undefined: hex = 28'h FFFFFFF (all segments off); no decoder logic is built.
  - led behaviour is identical in both cases.

Test Plan:
- Reset with DIVISOR=5: hold rst 2 cycles -> led=0, PC=8, state=FETCH; first tick occurs 5 clk after reset release.
- Program at 8: IN r1; OUT r1; STOP, with sw=9'h008 -> led=10'h008 after OUT; HALT remains stable for 1000 clk.
- Arithmetic: mem[1]=3, mem[2]=5; ADD r0,r1,r2; SUB r3,r2,r1; MUL r4,r1,r2; OUT r0/r3/r4 -> led shows 8, then 2, then 15 in order; ADD 16'hFFFF+1 -> 0.
- Indirect: mem[5]=6'd40, mem[40]=16'h0019; MOV r6,(r5); OUT r6 -> led=10'h019; MOV (r5),r1 writes mem[40].
- Live input: loop IN r1; OUT r1; jump by PC wrap of NOPs; change sw 008 -> 019 -> 003 -> led follows with at most one loop latency.
- With HEX_DISPLAY_EN: out_reg=16'h1A3F -> hex[6:0]=7'h0E (F), hex[13:7]=7'h30 (3), hex[20:14]=7'h08 (A), hex[27:21]=7'h79 (1); undefined -> hex all ones.
